// File: rtl/prog_ram16_loader_pkg.sv
// Shared definitions for the writable program memory and its byte-stream loader.
// PROG_AW/PROG_DW are the same geometry the CPU top and the ROM model use.
package prog_ram16_loader_pkg;

    localparam int PROG_AW = 4;
    localparam int PROG_DW = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/prog_ram16_loader_if.sv
// Load-stream port: the host drives start/valid/data, the loader answers with ready.
// Handshake: a byte transfers at a rising edge where ld_valid && ld_ready; ld_ready depends on loader state only.
interface prog_ram16_loader_if #(
    parameter int DW = prog_ram16_loader_pkg::PROG_DW
) ();

    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;

    modport master (
        output ld_start,
        output ld_valid,
        output ld_data,
        input  ld_ready
    );

    modport slave (
        input  ld_start,
        input  ld_valid,
        input  ld_data,
        output ld_ready
    );

endinterface

// File: rtl/prog_ram16_loader_ram16_8bit.sv
// 16x8 array: synchronous write, asynchronous read, tri-state bus drive.
// Read side matches rom16_8bit (addr, low_o_en, data_out) so the two are interchangeable.
module ram16_8bit
    import prog_ram16_loader_pkg::*;
#(
    parameter int AW = PROG_AW,
    parameter int DW = PROG_DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] addr,
    input  logic          low_o_en,
    output tri   [DW-1:0] data_out
);

    // Contents deliberately survive reset; only a load session rewrites them.
    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign data_out = low_o_en ? {DW{1'bz}} : mem_q[addr];

endmodule

// File: rtl/prog_ram16_loader.sv
// Program-memory loader: accepts 16 bytes plus a checksum byte, holds the CPU in
// clear while loading, and releases it only after the checksum verifies.
module prog_ram16_loader
    import prog_ram16_loader_pkg::*;
#(
    parameter int AW = PROG_AW,
    parameter int DW = PROG_DW
) (
    input  logic                  clk,
    input  logic                  clr,
    prog_ram16_loader_if.slave    ld,
    output logic                  cpu_hold,
    output logic                  ld_ok,
    output logic                  ld_err,
    input  logic [AW-1:0]         addr,
    input  logic                  low_o_en,
    output tri   [DW-1:0]         data_out,
    output state_t                dbg_state,
    output logic [AW-1:0]         dbg_wr_ptr,
    output logic                  dbg_rd_oe
);

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    state_t        state_q,    state_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [DW-1:0] csum_q,     csum_d;
    logic          ready_q,    ready_d;
    logic          hold_q,     hold_d;
    logic          ok_q,       ok_d;
    logic          err_q,      err_d;

    logic          xfer;
    logic          mem_we;
    logic [DW-1:0] csum_sum;
    logic          ram_oe_n;

    assign xfer     = ld.ld_valid & ready_q;
    assign csum_sum = csum_q + ld.ld_data;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        csum_d   = csum_q;
        ready_d  = ready_q;
        hold_d   = hold_q;
        ok_d     = ok_q;
        err_d    = err_q;
        mem_we   = 1'b0;

        // A restart wins over any byte offered in the same cycle.
        if (ld.ld_start) begin
            state_d  = LOAD;
            wr_ptr_d = '0;
            csum_d   = '0;
            ready_d  = 1'b1;
            hold_d   = 1'b1;
            ok_d     = 1'b0;
            err_d    = 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (xfer) begin
                        mem_we   = clr;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        csum_d   = csum_sum;
                        if (wr_ptr_q == LAST_ADDR) begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        ready_d = 1'b0;
                        if (csum_sum == '0) begin
                            state_d = RUN;
                            hold_d  = 1'b0;
                            ok_d    = 1'b1;
                        end else begin
                            state_d = ERR;
                            hold_d  = 1'b1;
                            err_d   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            csum_q   <= '0;
            ready_q  <= 1'b0;
            hold_q   <= 1'b1;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            csum_q   <= csum_d;
            ready_q  <= ready_d;
            hold_q   <= hold_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    // The bus is only driven once a verified program has released the CPU.
    assign ram_oe_n = low_o_en | hold_q;

    ram16_8bit #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk      (clk),
        .we       (mem_we),
        .waddr    (wr_ptr_q),
        .wdata    (ld.ld_data),
        .addr     (addr),
        .low_o_en (ram_oe_n),
        .data_out (data_out)
    );

    assign ld.ld_ready = ready_q;
    assign cpu_hold    = hold_q;
    assign ld_ok       = ok_q;
    assign ld_err      = err_q;
    assign dbg_state   = state_q;
    assign dbg_wr_ptr  = wr_ptr_q;
    assign dbg_rd_oe   = ~ram_oe_n;

endmodule
